// File: rtl/sbm_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sbm_arbiter
// Purpose  : Round-robin scheduler that shares one sequential binary
//            multiplier among N_REQ requesters. Picks a requester, latches
//            its operands, pulses the multiplier start for one cycle, waits
//            for the multiplier to report ready, then returns the product
//            with a one-cycle done pulse to the owner.
// Ports    :
//   clock            - rising-edge clock
//   reset_b          - asynchronous active-low reset (shared with multiplier)
//   req              - per-requester request level
//   multiplicand_in  - packed operand A per requester (i*DP_WIDTH +: DP_WIDTH)
//   multiplier_in    - packed operand B per requester, same packing
//   grant            - one-hot current owner
//   done             - one-cycle completion pulse to the owner
//   result           - last product, held until the next completion
//   busy             - high whenever the scheduler is not idle
//   mul_multiplicand - to multiplier Multiplicand
//   mul_multiplier   - to multiplier Multiplier
//   mul_start        - to multiplier Start (registered, one cycle)
//   mul_ready        - from multiplier Ready (high when idle)
//   mul_product      - from multiplier Product
// Revision : 1.0 - initial release
// ============================================================================
module sbm_arbiter #(
    parameter int DP_WIDTH = 5,
    parameter int N_REQ    = 4
) (
    input  logic                         clock,
    input  logic                         reset_b,
    input  logic [N_REQ-1:0]             req,
    input  logic [N_REQ*DP_WIDTH-1:0]    multiplicand_in,
    input  logic [N_REQ*DP_WIDTH-1:0]    multiplier_in,
    output logic [N_REQ-1:0]             grant,
    output logic [N_REQ-1:0]             done,
    output logic [2*DP_WIDTH-1:0]        result,
    output logic                         busy,
    output logic [DP_WIDTH-1:0]          mul_multiplicand,
    output logic [DP_WIDTH-1:0]          mul_multiplier,
    output logic                         mul_start,
    input  logic                         mul_ready,
    input  logic [2*DP_WIDTH-1:0]        mul_product
);

    localparam int c_PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LAUNCH = 3'd1,
        S_SETTLE = 3'd2,
        S_WAIT   = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t                  r_state;
    state_t                  w_next_state;

    logic [c_PTR_W-1:0]      r_ptr;
    logic [c_PTR_W-1:0]      r_owner;
    logic [N_REQ-1:0]        r_grant;
    logic [N_REQ-1:0]        r_done;
    logic [2*DP_WIDTH-1:0]   r_result;
    logic [DP_WIDTH-1:0]     r_mcand;
    logic [DP_WIDTH-1:0]     r_mplier;
    logic                    r_mul_start;

    logic                    w_pick_valid;
    logic [c_PTR_W-1:0]      w_pick_idx;
    logic [N_REQ-1:0]        w_pick_onehot;
    logic                    w_launch;

    // (base + offset) mod N_REQ, for offset in 0..N_REQ-1.
    function automatic logic [c_PTR_W-1:0] rr_index(input logic [c_PTR_W-1:0] base,
                                                    input int offset);
        int sum;
        sum = int'(base) + offset;
        if (sum >= N_REQ) begin
            sum = sum - N_REQ;
        end
        return sum[c_PTR_W-1:0];
    endfunction

    // Round-robin search starting at r_ptr. Iterating from the farthest
    // offset down lets the nearest requesting index overwrite the others.
    always_comb begin
        w_pick_valid = 1'b0;
        w_pick_idx   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req[rr_index(r_ptr, k)]) begin
                w_pick_valid = 1'b1;
                w_pick_idx   = rr_index(r_ptr, k);
            end
        end
    end

    always_comb begin
        w_pick_onehot = '0;
        w_pick_onehot[w_pick_idx] = 1'b1;
    end

    assign w_launch = (r_state == S_IDLE) && w_pick_valid && mul_ready;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   if (w_launch) w_next_state = S_LAUNCH;
            S_LAUNCH: w_next_state = S_SETTLE;
            // Ready may still show the pre-start idle value here; skip it.
            S_SETTLE: w_next_state = S_WAIT;
            S_WAIT:   if (mul_ready) w_next_state = S_DONE;
            S_DONE:   w_next_state = S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            r_ptr       <= '0;
            r_owner     <= '0;
            r_grant     <= '0;
            r_done      <= '0;
            r_result    <= '0;
            r_mcand     <= '0;
            r_mplier    <= '0;
            r_mul_start <= 1'b0;
        end else begin
            // Start is high only in LAUNCH, i.e. the cycle after a launch edge.
            r_mul_start <= w_launch;
            r_done      <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_launch) begin
                        r_grant  <= w_pick_onehot;
                        r_owner  <= w_pick_idx;
                        r_mcand  <= multiplicand_in[int'(w_pick_idx)*DP_WIDTH +: DP_WIDTH];
                        r_mplier <= multiplier_in[int'(w_pick_idx)*DP_WIDTH +: DP_WIDTH];
                    end
                end
                S_WAIT: begin
                    if (mul_ready) begin
                        r_result <= mul_product;
                        r_done   <= r_grant;
                    end
                end
                S_DONE: begin
                    r_grant <= '0;
                    // Owner moves to the back of the rotation.
                    r_ptr   <= rr_index(r_owner, 1);
                end
                default: begin
                end
            endcase
        end
    end

    assign grant            = r_grant;
    assign done             = r_done;
    assign result           = r_result;
    assign busy             = (r_state != S_IDLE);
    assign mul_multiplicand = r_mcand;
    assign mul_multiplier   = r_mplier;
    assign mul_start        = r_mul_start;

endmodule
`default_nettype wire

// File: doc/sbm_arbiter.md
# sbm_arbiter

Round-robin scheduler that shares one `Sequential_Binary_Multiplier` instance among `N_REQ` requesters. It arbitrates requests, latches the winner's operands, pulses the multiplier's `Start`, and waits for `Ready`. It then returns the product with a one-cycle `done` pulse to the winner. It sits between client blocks and the multiplier, and is the only driver of the multiplier's `Multiplicand`, `Multiplier` and `Start` inputs.

## Interface
- `DP_WIDTH`, 5, operand width; must match the multiplier's `dp_width`.
- `N_REQ`, 4, number of requesters (2..8).
- `clock` in 1: single clock, rising edge.
- `reset_b` in 1: asynchronous, active-low reset. It is shared with the multiplier.
- `req` in N_REQ: per-requester request level, held until that requester's `done`.
- `multiplicand_in` in N_REQ*DP_WIDTH: operand A for requester i, at bits [i*DP_WIDTH +: DP_WIDTH].
- `multiplier_in` in N_REQ*DP_WIDTH: operand B for requester i, same packing.
- `grant` out N_REQ: one-hot; the current owner of the multiplier.
- `done` out N_REQ: one-cycle pulse to the owner when `result` is valid.
- `result` out 2*DP_WIDTH: last product. Holds its value until the next completion.
- `busy` out 1: high whenever the state is not IDLE.
- `mul_multiplicand` out DP_WIDTH: connects to the multiplier's `Multiplicand`.
- `mul_multiplier` out DP_WIDTH: connects to the multiplier's `Multiplier`.
- `mul_start` out 1: connects to the multiplier's `Start`. Registered.
- `mul_ready` in 1: from the multiplier's `Ready`; high when the multiplier is idle.
- `mul_product` in 2*DP_WIDTH: from the multiplier's `Product`.

## Operation
- FSM states and transitions:
  - IDLE → LAUNCH when `|req` and `mul_ready`. Otherwise stay in IDLE.
  - LAUNCH → SETTLE unconditionally.
  - SETTLE → WAIT unconditionally.
  - WAIT → DONE when `mul_ready`=1.
  - DONE → IDLE unconditionally.
- IDLE:
  - Round-robin pick: the first i with `req[i]`=1, searching `ptr`, `ptr+1`, … mod N_REQ.
  - On the transition edge: register `grant` to one-hot(i) and latch operands i into `mul_multiplicand`/`mul_multiplier`.
- LAUNCH: `mul_start`=1 for exactly this cycle. This is the only cycle in which `mul_start` is high.
- SETTLE: `mul_ready` is ignored, so a stale idle `Ready` is not mistaken for completion.
- WAIT: on the edge where `mul_ready`=1, `result` ← `mul_product`.
- DONE:
  - `done[g]`=1 for the owner g.
  - `ptr` ← (g+1) mod N_REQ on exit.
  - `grant` clears on the DONE→IDLE edge.
- Operand rules:
  - Operands are sampled only on the IDLE→LAUNCH edge; later changes to `*_in` are ignored.
  - `mul_*` operand outputs hold their values until the next grant.
- Arithmetic: operands are unsigned. `result` is the unmodified 2*DP_WIDTH product; the arbiter performs no truncation or extension.
- Boundary conditions:
  - Requester drops `req` mid-operation: the operation still completes and `done` still pulses, because the multiplier cannot be aborted.
  - `req` asserted during LAUNCH..DONE: not serviced until the next IDLE cycle.
  - Owner re-asserts `req` in DONE: it goes to the back of the rotation because `ptr` has advanced.
  - `mul_ready`=0 in IDLE (multiplier still busy after reset): no grant is issued.
  - Only one operation is ever outstanding.

## Timing
- Reset (asynchronous, immediate):
  - State = IDLE, `ptr` = 0.
  - `grant`, `done`, `result`, `busy`, `mul_start`, `mul_multiplicand`, `mul_multiplier` all 0.
  - Reset mid-operation abandons the operation with no `done` pulse; the multiplier is reset by the same `reset_b`.
- Request to grant: 1 cycle. `req` is seen at edge k; `grant` and `busy` are high after edge k; `mul_start` is high between edges k and k+1.
- Done timing: `done` is high for the one cycle after the edge at which WAIT sees `mul_ready`. `result` is valid from that same edge.
- Total cycles per job: 4 + (multiplier busy cycles). Back-to-back jobs have 1 IDLE cycle between `done` and the next `grant`.
- `grant` is stable from LAUNCH through DONE. `busy` = `grant` != 0.

## Test plan
- Single request:
  - Stimulus: `req`=0010, requester 1 operands 10111 (23) × 10011 (19).
  - Response: `grant`=0010 one cycle later; exactly one `mul_start` pulse; `done`=0010 for one cycle; `result`=0110110101 (437).
- All four request after reset:
  - Stimulus: operands (31,31), (1,1), (0,17), (12,5).
  - Response: grants in order 0001, 0010, 0100, 1000; results 961, 1, 0, 60; `mul_start` never overlaps a busy multiplier.
- Round-robin:
  - Stimulus: after req0 is served, req0 and req2 are asserted together.
  - Response: req2 is granted first, then req0.
- Operand sampling:
  - Stimulus: change requester 1's operands to 0×0 one cycle after grant.
  - Response: `result` still equals 437.
- Reset mid-WAIT:
  - Stimulus: pulse `reset_b` low while in WAIT.
  - Response: all outputs go to 0 immediately with no `done`. After release, with `req` still held, a fresh job completes with the correct product.
- Multiplier not ready:
  - Stimulus: hold `mul_ready`=0 in IDLE with `req`=0001.
  - Response: no `grant` until `mul_ready` rises; `grant` follows on the next edge.
